// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings, state/class enums and the instruction classifier
// for the multi-cycle control sequencer.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_MEMJ  = 4'b0100;
    localparam logic [3:0] OP_ADD   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_CMP   = 4'b1011;
    localparam logic [3:0] OP_AND   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_MOV   = 4'b1101;
    localparam logic [3:0] OP_LSHI  = 4'b1000;
    localparam logic [3:0] OP_LUI   = 4'b1111;
    localparam logic [3:0] OP_BCOND = 4'b1100;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_FAULT
    } state_e;

    typedef enum logic [2:0] {
        CL_ALU, CL_ALU_FLAG, CL_CMP, CL_BRANCH, CL_JAL, CL_LOAD, CL_STOR, CL_ILLEGAL
    } class_e;

    function automatic logic imm_sel(input logic [3:0] op);
        return !(op == OP_RTYPE || op == OP_MEMJ);
    endfunction

    // Same ALU code space is shared by the R-type ext field and the immediate opcode.
    function automatic class_e alu_class(input logic [3:0] code);
        case (code)
            OP_ADD, OP_SUB:                 return CL_ALU_FLAG;
            OP_CMP:                         return CL_CMP;
            OP_AND, OP_OR, OP_XOR, OP_MOV:  return CL_ALU;
            default:                        return CL_ILLEGAL;
        endcase
    endfunction

    function automatic class_e classify(input logic [3:0] op, input logic [3:0] ext);
        if (op == OP_RTYPE) return alu_class(ext);
        if (op == OP_MEMJ) begin
            case (ext)
                EXT_LOAD:  return CL_LOAD;
                EXT_STOR:  return CL_STOR;
                EXT_JAL:   return CL_JAL;
                EXT_JCOND: return CL_BRANCH;
                default:   return CL_ILLEGAL;
            endcase
        end
        case (op)
            OP_LSHI, OP_LUI: return CL_ALU;
            OP_BCOND:        return CL_BRANCH;
            default:         return alu_class(op);
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has been waiting; flags the cycle whose
// increment would reach LIMIT so the sequencer can fault on the next edge.
module mem_wait_timer #(
    parameter int LIMIT = 16,
    parameter int W     = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)         cnt_d = '0;
        else if (count_en_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired_o = count_en_i && (cnt_q == LAST);

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer: fetch, decode, execute, memory, writeback.
//   FETCH  | instruction read from PC address, ir_load on ack
//   DECODE | classify opcode, illegal encodings halt
//   EXEC   | ALU strobes, branches/jumps, CMP retires here
//   MEM    | data read/write at Rsrc address
//   WB     | register file write, PC increment
//   HALT   | illegal instruction, parked until reset
//   FAULT  | memory timeout, parked until reset
module cpu_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMR_W       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode_i,
    input  logic [3:0] opcode_ext_i,
    input  logic       cond_met_i,
    input  logic       mem_ack_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       addr_sel_o,
    output logic       ir_load_o,
    output logic       s_o,
    output logic [3:0] alu_op_o,
    output logic       flag_we_o,
    output logic       reg_we_o,
    output logic [1:0] wb_sel_o,
    output logic       pc_inc_o,
    output logic       pc_load_o,
    output logic       halted_o,
    output logic       fault_o
);

    state_e state_q, state_d;
    class_e class_q, class_d;
    logic   tmr_clear, tmr_expired;

    assign s_o = imm_sel(opcode_i);

    mem_wait_timer #(.LIMIT(MEM_TIMEOUT), .W(TMR_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (tmr_clear),
        .count_en_i (mem_req_o && !mem_ack_i),
        .expired_o  (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            class_q <= CL_ALU;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        addr_sel_o = 1'b0;
        ir_load_o  = 1'b0;
        alu_op_o   = 4'd0;
        flag_we_o  = 1'b0;
        reg_we_o   = 1'b0;
        wb_sel_o   = WB_ALU;
        pc_inc_o   = 1'b0;
        pc_load_o  = 1'b0;
        halted_o   = 1'b0;
        fault_o    = 1'b0;
        // Strobes are gated by rst_n so a reset mid-request drops them without a clock.
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req_o = 1'b1;
                    if (mem_ack_i) begin
                        ir_load_o = 1'b1;
                        state_d   = ST_DECODE;
                    end else if (tmr_expired) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_DECODE: begin
                    class_d = classify(opcode_i, opcode_ext_i);
                    state_d = (class_d == CL_ILLEGAL) ? ST_HALT : ST_EXEC;
                end
                ST_EXEC: begin
                    alu_op_o = s_o ? opcode_i : opcode_ext_i;
                    case (class_q)
                        CL_ALU:      state_d = ST_WB;
                        CL_ALU_FLAG: begin flag_we_o = 1'b1; state_d = ST_WB; end
                        CL_CMP: begin
                            flag_we_o = 1'b1;
                            pc_inc_o  = 1'b1;
                            state_d   = ST_FETCH;
                        end
                        CL_BRANCH: begin
                            pc_load_o = cond_met_i;
                            pc_inc_o  = !cond_met_i;
                            state_d   = ST_FETCH;
                        end
                        CL_JAL: begin
                            reg_we_o  = 1'b1;
                            wb_sel_o  = WB_LINK;
                            pc_load_o = 1'b1;
                            state_d   = ST_FETCH;
                        end
                        CL_LOAD, CL_STOR: state_d = ST_MEM;
                        default:          state_d = ST_HALT;
                    endcase
                end
                ST_MEM: begin
                    mem_req_o  = 1'b1;
                    addr_sel_o = 1'b1;
                    mem_we_o   = (class_q == CL_STOR);
                    if (mem_ack_i) begin
                        if (class_q == CL_STOR) begin
                            pc_inc_o = 1'b1;
                            state_d  = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end else if (tmr_expired) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_WB: begin
                    reg_we_o = 1'b1;
                    pc_inc_o = 1'b1;
                    wb_sel_o = (class_q == CL_LOAD) ? WB_MEM : WB_ALU;
                    state_d  = ST_FETCH;
                end
                ST_HALT:  halted_o = 1'b1;
                ST_FAULT: begin halted_o = 1'b1; fault_o = 1'b1; end
                default:  state_d = ST_HALT;
            endcase
        end
    end

    assign tmr_clear = (state_d != state_q) && (state_d == ST_FETCH || state_d == ST_MEM);

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed-vector bench for the control sequencer; expected output words are
// hand-built per cycle from named strobe bits.
module tb_cpu_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode_i = 4'd0;
    logic [3:0] opcode_ext_i = 4'd0;
    logic       cond_met_i = 1'b0;
    logic       mem_ack_i = 1'b0;
    logic       mem_req_o, mem_we_o, addr_sel_o, ir_load_o, s_o;
    logic [3:0] alu_op_o;
    logic       flag_we_o, reg_we_o;
    logic [1:0] wb_sel_o;
    logic       pc_inc_o, pc_load_o, halted_o, fault_o;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [16:0] REQ  = 17'h10000;
    localparam logic [16:0] WE   = 17'h08000;
    localparam logic [16:0] ASEL = 17'h04000;
    localparam logic [16:0] IRL  = 17'h02000;
    localparam logic [16:0] S    = 17'h01000;
    localparam logic [16:0] FW   = 17'h00080;
    localparam logic [16:0] RW   = 17'h00040;
    localparam logic [16:0] PI   = 17'h00008;
    localparam logic [16:0] PL   = 17'h00004;
    localparam logic [16:0] H    = 17'h00002;
    localparam logic [16:0] F    = 17'h00001;
    localparam logic [16:0] NONE = 17'h00000;

    function automatic logic [16:0] alu(input logic [3:0] x);
        return {5'b0, x, 8'b0};
    endfunction

    function automatic logic [16:0] wbs(input logic [1:0] x);
        return {11'b0, x, 4'b0};
    endfunction

    logic [16:0] obs;
    assign obs = {mem_req_o, mem_we_o, addr_sel_o, ir_load_o, s_o, alu_op_o,
                  flag_we_o, reg_we_o, wb_sel_o, pc_inc_o, pc_load_o, halted_o, fault_o};

    cpu_control_fsm #(.MEM_TIMEOUT(16), .TMR_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode_i     (opcode_i),
        .opcode_ext_i (opcode_ext_i),
        .cond_met_i   (cond_met_i),
        .mem_ack_i    (mem_ack_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .addr_sel_o   (addr_sel_o),
        .ir_load_o    (ir_load_o),
        .s_o          (s_o),
        .alu_op_o     (alu_op_o),
        .flag_we_o    (flag_we_o),
        .reg_we_o     (reg_we_o),
        .wb_sel_o     (wb_sel_o),
        .pc_inc_o     (pc_inc_o),
        .pc_load_o    (pc_load_o),
        .halted_o     (halted_o),
        .fault_o      (fault_o)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; mem_ack_i = 1'b0; opcode_i = 4'd0; opcode_ext_i = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ack_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (obs !== NONE) begin
            miscompares++;
            $display("FAIL reset_hold: outputs %h expected %h", obs, NONE);
        end
        @(negedge clk);
        mem_ack_i = 1'b0; rst_n = 1'b1;
        #1;
        vectors++;
        if (obs !== REQ) begin
            miscompares++;
            $display("FAIL reset_release: outputs %h expected %h", obs, REQ);
        end
    endtask

    task automatic test_add();
        logic [16:0] e [4];
        logic        a [4];
        e = '{REQ | IRL, NONE, alu(4'b0101) | FW, RW | PI};
        a = '{1'b1, 1'b1, 1'b1, 1'b0};
        opcode_i = 4'b0000; opcode_ext_i = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ack_i = a[i]; #1;
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL add c%0d: outputs %h expected %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_addi();
        logic [16:0] e [4];
        logic        a [4];
        e = '{REQ | IRL | S, S, S | alu(4'b0101) | FW, S | RW | PI};
        a = '{1'b1, 1'b0, 1'b0, 1'b0};
        opcode_i = 4'b0101; opcode_ext_i = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ack_i = a[i]; #1;
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL addi c%0d: outputs %h expected %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_alu_classes();
        logic [16:0] e [11];
        logic        a [11];
        logic [3:0]  op [11];
        logic [3:0]  ex [11];
        // AND (no flags), CMP (retires in EXEC), LSHI (immediate, no flags)
        e  = '{REQ | IRL, NONE, alu(4'b0001), RW | PI,
               REQ | IRL, NONE, alu(4'b1011) | FW | PI,
               REQ | IRL | S, S, S | alu(4'b1000), S | RW | PI};
        a  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        op = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8};
        ex = '{4'h1, 4'h1, 4'h1, 4'h1, 4'hB, 4'hB, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk); mem_ack_i = a[i]; opcode_i = op[i]; opcode_ext_i = ex[i]; #1;
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL alu_class c%0d: outputs %h expected %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_load();
        logic [16:0] e [8];
        logic        a [8];
        e = '{REQ | IRL, NONE, NONE, REQ | ASEL, REQ | ASEL, REQ | ASEL, REQ | ASEL,
              RW | PI | wbs(2'd1)};
        a = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        opcode_i = 4'b0100; opcode_ext_i = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); mem_ack_i = a[i]; #1;
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL load c%0d: outputs %h expected %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_store();
        logic [16:0] e [4];
        logic        a [4];
        e = '{REQ | IRL, NONE, alu(4'b0100), REQ | WE | ASEL | PI};
        a = '{1'b1, 1'b0, 1'b0, 1'b1};
        opcode_i = 4'b0100; opcode_ext_i = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ack_i = a[i]; #1;
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL store c%0d: outputs %h expected %h", i, obs, e[i]);
            end
        end
        @(negedge clk); mem_ack_i = 1'b0;
    endtask

    task automatic test_branch();
        logic [16:0] e [6];
        logic        a [6];
        logic        c [6];
        e = '{REQ | IRL | S, S, S | alu(4'b1100) | PL,
              REQ | IRL | S, S, S | alu(4'b1100) | PI};
        a = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        c = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        opcode_i = 4'b1100; opcode_ext_i = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); mem_ack_i = a[i]; cond_met_i = c[i]; #1;
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL bcond c%0d: outputs %h expected %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_jal();
        logic [16:0] e [3];
        logic        a [3];
        e = '{REQ | IRL, NONE, alu(4'b1000) | RW | wbs(2'd2) | PL};
        a = '{1'b1, 1'b0, 1'b0};
        opcode_i = 4'b0100; opcode_ext_i = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_ack_i = a[i]; #1;
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL jal c%0d: outputs %h expected %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_ack_at_limit();
        logic [16:0] exp_v;
        opcode_i = 4'b0000; opcode_ext_i = 4'b0101;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk); mem_ack_i = (i == 15); #1;
            if (i < 15)       exp_v = REQ;
            else if (i == 15) exp_v = REQ | IRL;
            else if (i == 16) exp_v = NONE;
            else if (i == 17) exp_v = alu(4'b0101) | FW;
            else              exp_v = RW | PI;
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL ack_at_limit c%0d: outputs %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_timeout();
        logic [16:0] exp_v;
        opcode_i = 4'b0000; opcode_ext_i = 4'b0101;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk); mem_ack_i = (i == 17); #1;
            exp_v = (i < 16) ? REQ : (H | F);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL timeout c%0d: outputs %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_illegal();
        logic [16:0] e [4];
        logic        a [4];
        e = '{REQ | IRL | S, S, S | H, S | H};
        a = '{1'b1, 1'b0, 1'b0, 1'b1};
        opcode_i = 4'b0110; opcode_ext_i = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ack_i = a[i]; #1;
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL illegal_op c%0d: outputs %h expected %h", i, obs, e[i]);
            end
        end
        do_reset();
        e = '{REQ | IRL, NONE, H, H};
        a = '{1'b1, 1'b0, 1'b0, 1'b0};
        opcode_i = 4'b0000; opcode_ext_i = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ack_i = a[i]; #1;
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL illegal_ext c%0d: outputs %h expected %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [16:0] e [4];
        logic        a [4];
        e = '{REQ | IRL, NONE, NONE, REQ | ASEL};
        a = '{1'b1, 1'b0, 1'b0, 1'b0};
        opcode_i = 4'b0100; opcode_ext_i = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ack_i = a[i]; #1;
            vectors++;
            if (obs !== e[i]) begin
                miscompares++;
                $display("FAIL mid_mem c%0d: outputs %h expected %h", i, obs, e[i]);
            end
        end
        rst_n = 1'b0; #1;
        vectors++;
        if (obs !== NONE) begin
            miscompares++;
            $display("FAIL mid_mem_async_drop: outputs %h expected %h", obs, NONE);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        vectors++;
        if (obs !== REQ) begin
            miscompares++;
            $display("FAIL mid_mem_restart: outputs %h expected %h", obs, REQ);
        end
        @(negedge clk); mem_ack_i = 1'b1; #1;
        vectors++;
        if (obs !== (REQ | IRL)) begin
            miscompares++;
            $display("FAIL mid_mem_refetch: outputs %h expected %h", obs, REQ | IRL);
        end
        @(negedge clk); mem_ack_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_addi();
        test_alu_classes();
        test_load();
        test_store();
        test_branch();
        test_jal();
        test_ack_at_limit();
        test_timeout();
        do_reset();
        test_illegal();
        do_reset();
        test_reset_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
